// File: rtl/stream_pack_src.sv
// rtl/stream_pack_src.sv - source-domain narrow-to-wide stream packer feeding the CDC FIFO
// Optional idle flush of partial words: STREAM_PACK_TIMEOUT_EN
module stream_pack_src #(
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned RATIO    = 4,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                         src_clk_i,
    input  logic                         src_rst_ni,
    input  logic [IN_WIDTH-1:0]          in_data_i,
    input  logic                         in_last_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    output logic [IN_WIDTH*RATIO-1:0]    out_data_o,
    output logic [RATIO-1:0]             out_keep_o,
    output logic                         out_last_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic                         busy_o
);

    localparam int unsigned OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int unsigned LANE_W    = $clog2(RATIO);
    localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(RATIO - 1);

    logic [LANE_W-1:0]    lane_q, lane_d;
    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic [RATIO-1:0]     out_keep_q, out_keep_d;
    logic                 out_last_q, out_last_d;
    logic                 out_valid_q, out_valid_d;

    logic                 out_free;
    logic                 flush;
    logic                 in_hs;
    logic                 completing;
    logic [OUT_WIDTH-1:0] merged;
    logic [RATIO-1:0]     keep_upto;
    logic [RATIO-1:0]     keep_below;

    // Output register can take a new word if empty or being drained this cycle.
    assign out_free = !out_valid_q || out_ready_i;

`ifdef STREAM_PACK_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

    logic [IDLE_W-1:0] idle_q, idle_d;

    assign flush = (lane_q != '0) && (idle_q == IDLE_MAX) && out_free;

    always_comb begin
        idle_d = idle_q;
        if (in_hs || flush || (lane_q == '0)) begin
            idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
        if (!src_rst_ni) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign flush = 1'b0;
`endif

    // Input is blocked during a flush so the flushed word and a new beat never collide.
    assign in_ready_o = out_free && !flush;
    assign in_hs      = in_valid_i && in_ready_o;
    assign completing = in_hs && ((lane_q == LANE_MAX) || in_last_i);

    // Lanes above lane_q are always zero in the accumulator, so no extra masking is needed.
    always_comb begin
        merged = acc_q;
        merged[int'(lane_q) * IN_WIDTH +: IN_WIDTH] = in_data_i;
        for (int i = 0; i < RATIO; i++) begin
            keep_upto[i]  = (i <= int'(lane_q));
            keep_below[i] = (i <  int'(lane_q));
        end
    end

    always_comb begin
        lane_d      = lane_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end

        if (completing) begin
            out_data_d  = merged;
            out_keep_d  = keep_upto;
            out_last_d  = in_last_i;
            out_valid_d = 1'b1;
            lane_d      = '0;
            acc_d       = '0;
        end else if (in_hs) begin
            acc_d  = merged;
            lane_d = lane_q + 1'b1;
        end else if (flush) begin
            out_data_d  = acc_q;
            out_keep_d  = keep_below;
            out_last_d  = 1'b0;
            out_valid_d = 1'b1;
            lane_d      = '0;
            acc_d       = '0;
        end
    end

    always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
        if (!src_rst_ni) begin
            lane_q      <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            lane_q      <= lane_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_keep_o  = out_keep_q;
    assign out_last_o  = out_last_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = (lane_q != '0) || out_valid_q;

endmodule

// File: tb/tb_stream_pack_src.sv
// tb/tb_stream_pack_src.sv - directed self-checking bench for stream_pack_src
module tb_stream_pack_src;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int stalls   = 0;
    int first_acc;

    logic [31:0] q_data[$];
    logic [3:0]  q_keep[$];
    logic        q_last[$];
    int          q_edge[$];

    always #5 clk = ~clk;

    stream_pack_src #(.IN_WIDTH(8), .RATIO(4), .TIMEOUT(16)) dut (
        .src_clk_i   (clk),
        .src_rst_ni  (rstn),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_data_o  (out_data),
        .out_keep_o  (out_keep),
        .out_last_o  (out_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .busy_o      (busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs only change at posedge+1, so at negedge they hold for the coming edge.
    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            q_data.push_back(out_data);
            q_keep.push_back(out_keep);
            q_last.push_back(out_last);
            q_edge.push_back(cyc + 1);
        end
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_data.delete();
        q_keep.delete();
        q_last.delete();
        q_edge.delete();
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l);
        bit done = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            else stalls++;
            step();
        end
        if (!done) check_val("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // reset state
        step(); step();
        check_val("rst_valid", out_valid, 0);
        check_val("rst_data",  out_data,  0);
        check_val("rst_keep",  out_keep,  0);
        check_val("rst_last",  out_last,  0);
        check_val("rst_busy",  busy,      0);
        check_val("rst_ready", in_ready,  1);
        rstn = 1'b1;
        step();

        // 1: full word
        clear_q();
        send_beat(8'h11, 0); send_beat(8'h22, 0); send_beat(8'h33, 0); send_beat(8'h44, 0);
        check_val("t1_valid", out_valid, 1);
        check_val("t1_data",  out_data,  32'h44332211);
        check_val("t1_keep",  out_keep,  4'hF);
        check_val("t1_last",  out_last,  0);
        step();
        check_val("t1_count", q_data.size(), 1);
        check_val("t1_valid_clr", out_valid, 0);

        // 2: short packet
        clear_q();
        send_beat(8'hAA, 0); send_beat(8'hBB, 1);
        check_val("t2_data", out_data, 32'h0000BBAA);
        check_val("t2_keep", out_keep, 4'h3);
        check_val("t2_last", out_last, 1);
        step();
        check_val("t2_count", q_data.size(), 1);

        // 3: backpressure
        clear_q();
        out_ready = 1'b0;
        send_beat(8'hC1, 0); send_beat(8'hC2, 0); send_beat(8'hC3, 0); send_beat(8'hC4, 0);
        in_valid = 1'b1; in_data = 8'hD1; in_last = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("t3_stall_ready", in_ready, 0);
            check_val("t3_stall_data",  {out_valid, out_keep, out_data}, {1'b1, 4'hF, 32'hC4C3C2C1});
        end
        step();
        out_ready = 1'b1;
        @(negedge clk);
        check_val("t3_ready_release", in_ready, 1);
        step();
        in_valid = 1'b0;
        check_val("t3_drained", q_data.size(), 1);
        if (q_data.size() > 0) check_val("t3_drain_data", q_data[0], 32'hC4C3C2C1);
        check_val("t3_valid_after", out_valid, 0);
        check_val("t3_busy_after", busy, 1);
        send_beat(8'hD2, 0); send_beat(8'hD3, 0); send_beat(8'hD4, 0);
        check_val("t3_next_data", out_data, 32'hD4D3D2D1);
        check_val("t3_next_keep", out_keep, 4'hF);
        step();

        // 4: reset mid-packet
        clear_q();
        send_beat(8'hE1, 0); send_beat(8'hE2, 0);
        rstn = 1'b0;
        #1;
        check_val("t4_rst_out", {out_valid, out_last, out_keep, out_data}, 0);
        check_val("t4_rst_busy", busy, 0);
        step(); step();
        check_val("t4_rst_hold", {out_valid, busy, in_ready}, 3'b001);
        rstn = 1'b1;
        step();
        send_beat(8'h01, 0); send_beat(8'h02, 0); send_beat(8'h03, 0); send_beat(8'h04, 0);
        step();
        check_val("t4_count", q_data.size(), 1);
        if (q_data.size() > 0) begin
            check_val("t4_data", q_data[0], 32'h04030201);
            check_val("t4_keep", q_keep[0], 4'hF);
        end

        // 5: three words back to back
        clear_q();
        stalls = 0;
        for (int w = 0; w < 3; w++) begin
            for (int b = 0; b < 4; b++) begin
                send_beat(8'((w << 4) | (b + 1)), 0);
                if (w == 0 && b == 0) first_acc = cyc;
            end
        end
        step();
        check_val("t5_stalls", stalls, 0);
        check_val("t5_count", q_data.size(), 3);
        if (q_data.size() == 3) begin
            check_val("t5_w0", q_data[0], 32'h04030201);
            check_val("t5_w1", q_data[1], 32'h14131211);
            check_val("t5_w2", q_data[2], 32'h24232221);
            check_val("t5_lat0", q_edge[0] - first_acc, 4);
            check_val("t5_gap1", q_edge[1] - q_edge[0], 4);
            check_val("t5_gap2", q_edge[2] - q_edge[1], 4);
        end

        // 6: lone beat then idle
        clear_q();
        send_beat(8'h5A, 0);
        first_acc = cyc;
`ifdef STREAM_PACK_TIMEOUT_EN
        begin
            bit seen = 0;
            int lat = 0;
            for (int t = 0; t < 40 && !seen; t++) begin
                if (out_valid) begin
                    seen = 1;
                    lat = cyc - first_acc;
                end else begin
                    step();
                end
            end
            check_val("t6_flush_seen", seen, 1);
            check_val("t6_flush_lat_ok", (lat >= 16 && lat <= 17), 1);
            check_val("t6_flush_data", out_data, 32'h0000005A);
            check_val("t6_flush_keep", out_keep, 4'h1);
            check_val("t6_flush_last", out_last, 0);
        end
`else
        for (int t = 0; t < 100; t++) step();
        check_val("t6_no_out", q_data.size(), 0);
        check_val("t6_valid", out_valid, 0);
        check_val("t6_busy", busy, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
